load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter SIZE, default `MEM_SIZE, the byte size of the attached memory; it bounds the legal address range.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  CPU request present.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3_i  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata_o  output  32  formatted load data.
REQ-012 SHALL have port resp_err_o  output  1  request rejected: misaligned, illegal funct3, or address >= SIZE.
REQ-013 SHALL have port mem_addr_o  output  32  word-aligned memory address.
REQ-014 SHALL have port mem_rstrb_o  output  1  memory read strobe.
REQ-015 SHALL have port mem_rdata_i  input  32  memory read data, valid the cycle after the strobe.
REQ-016 SHALL have port mem_wmask_o  output  4  byte write enables.
REQ-017 SHALL have port mem_wdata_o  output  32  lane-replicated store data.

Function
REQ-018 States: IDLE, ISSUE, RESP; req_ready_o = (state == IDLE).
REQ-019 Accept on an edge with req_valid_i & req_ready_o: register we, funct3, addr and wdata; go to ISSUE if legal, otherwise to RESP with an error flag.
REQ-020 Legality: load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}; halfword needs addr[0]=0; word needs addr[1:0]=0; addr < SIZE.
REQ-021 ISSUE lasts exactly one cycle:
- mem_addr_o = {addr[31:2],2'b00}.
- Load: mem_rstrb_o=1, mem_wmask_o=0.
- Store: mem_rstrb_o=0, mem_wmask_o per REQ-022.
- Then go to RESP.
REQ-022 Store mask and data:
- SB: mask 4'b0001<<addr[1:0], wdata {4{wdata[7:0]}}.
- SH: mask 4'b0011<<{addr[1],1'b0}, wdata {2{wdata[15:0]}}.
- SW: mask 4'b1111, wdata unchanged.
REQ-023 RESP lasts one cycle: resp_valid_o=1, then go to IDLE; load latency is 2 cycles after acceptance (accept edge, ISSUE, RESP).
REQ-024 Load formatting in RESP from mem_rdata_i:
- LB/LBU: byte at lane addr[1:0], sign- or zero-extended.
- LH/LHU: halfword at addr[1], sign- or zero-extended.
- LW: full word.
REQ-025 Outside RESP, resp_rdata_o=0; store and error responses SHALL drive resp_rdata_o=0.
REQ-026 resp_err_o SHALL be 1 only in RESP of a rejected request; a rejected request SHALL never assert mem_rstrb_o or any mem_wmask_o bit.
REQ-027 Outside ISSUE: mem_rstrb_o=0, mem_wmask_o=0; mem_addr_o and mem_wdata_o hold their last values.
REQ-028 At most one memory access per request; req_* inputs SHALL be ignored while req_ready_o=0.
REQ-029 A new request can be accepted in the cycle after RESP; sustained throughput is one request per 3 cycles.

Reset
REQ-030 While rst=1, state <= IDLE, and mem_rstrb_o, mem_wmask_o, resp_valid_o and resp_err_o SHALL be 0 in the same cycle (gated), including when rst is asserted during ISSUE.
REQ-031 After reset: mem_addr_o=0, mem_wdata_o=0, resp_rdata_o=0, req_ready_o=1 in the first cycle with rst=0.
REQ-032 Reset mid-operation SHALL abort the transaction with no response pulse.

Verification
REQ-033 SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> ISSUE wmask=1111, wdata=0xDEADBEEF; load resp_rdata_o=0xDEADBEEF two cycles after acceptance, resp_err_o=0.
REQ-034 SB 0x13 data 0x000000A5 -> wmask=1000, wdata=0xA5A5A5A5; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
REQ-035 SH 0x16 data 0x8001 -> wmask=1100; LH 0x16 -> 0xFFFF8001; LHU 0x16 -> 0x00008001.
REQ-036 LW 0x02, SH 0x01, funct3=011 load, and LW to address SIZE -> each gives resp_valid_o=1 and resp_err_o=1 one cycle after acceptance, with no strobe or mask activity.
REQ-037 rst asserted in the ISSUE cycle of an SW -> mem_wmask_o=0 that cycle, no resp_valid_o, req_ready_o=1 after release, memory word unchanged.
REQ-038 req_valid_i held high continuously with back-to-back requests -> acceptances exactly every 3 cycles, and req_* changes while req_ready_o=0 have no effect.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one RV32I load or store request from the CPU, checks
// that it is legal, and performs at most one access on a word-addressed
// memory port. IDLE -> ISSUE -> RESP for legal requests. IDLE -> RESP with an
// error flag for rejected ones. A new request is taken once every 3 cycles.
// Handshake: a request is accepted on a rising edge where req_valid_i and
// req_ready_o are both 1. req_ready_o is 1 only in IDLE. The req_* inputs are
// ignored while it is 0. resp_valid_o is a one-cycle pulse with no back-pressure.

`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

module load_store_unit #(
  parameter int SIZE = `MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Extra top bit so that an address of 0xFFFF_FFFF compares correctly.
  localparam logic [32:0] SIZE_LIM = 33'(SIZE);

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        err_q;

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic [31:0] store_data;
  logic [3:0]  store_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        in_issue;
  logic        in_resp;

  // Decide whether the request on the input port may touch memory.
  always_comb begin
    f3_ok = 1'b0;
    if (req_we_i) begin
      f3_ok = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
              (req_funct3_i == 3'b010);
    end else begin
      f3_ok = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
              (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
              (req_funct3_i == 3'b101);
    end
    case (req_funct3_i[1:0])
      2'b01:   align_ok = ~req_addr_i[0];
      2'b10:   align_ok = (req_addr_i[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = ({1'b0, req_addr_i} < SIZE_LIM);
    legal    = f3_ok & align_ok & range_ok;
  end

  // Replicate store data across the lanes it may land in.
  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   store_data = {4{req_wdata_i[7:0]}};
      2'b01:   store_data = {2{req_wdata_i[15:0]}};
      default: store_data = req_wdata_i;
    endcase
  end

  // Byte enables for the registered store, used only in ISSUE.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   store_mask = 4'b0001 << lane_q;
      2'b01:   store_mask = 4'b0011 << {lane_q[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  end

  // Pick and extend the load lane from the word returned by memory.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Request FSM. Memory address and write data are loaded at acceptance so
  // they are stable through ISSUE and hold their values afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      err_q       <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            lane_q   <= req_addr_i[1:0];
            err_q    <= ~legal;
            if (legal) begin
              mem_addr_o <= {req_addr_i[31:2], 2'b00};
              if (req_we_i) begin
                mem_wdata_o <= store_data;
              end
              state <= ISSUE;
            end else begin
              state <= RESP;
            end
          end
        end
        ISSUE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and response flags are gated by rst in the same cycle, so an
  // access in flight when reset arrives never reaches memory or the CPU.
  assign in_issue     = (state == ISSUE) & ~rst;
  assign in_resp      = (state == RESP) & ~rst;
  assign req_ready_o  = (state == IDLE);
  assign mem_rstrb_o  = in_issue & ~we_q;
  assign mem_wmask_o  = (in_issue & we_q) ? store_mask : 4'b0000;
  assign resp_valid_o = in_resp;
  assign resp_err_o   = in_resp & err_q;
  assign resp_rdata_o = (in_resp & ~we_q & ~err_q) ? ld_data : 32'd0;
  assign dbg_state    = state;

endmodule
